prio_enc_serializer: RTL and testbench
======================================

# prio_enc_serializer

Sequential 2^N-to-N priority encoder, the inverse of the team's 2-to-4 one-hot decoder. It accepts a multi-hot request vector over a valid/ready handshake and emits the binary index of every set bit, one index per output handshake, highest priority first. It sits upstream of the decoder in request/grant paths, so an encoded index can be re-expanded downstream.

## Interface
- N, default 2: index width; the request vector is 2^N bits wide.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  req is valid this cycle.
- in_ready  out  1  block can accept a vector this cycle.
- req  in  2^N  multi-hot request vector.
- flush  in  1  synchronous abort; discards the pending vector.
- out_valid  out  1  idx/last valid this cycle.
- out_ready  in  1  consumer accepts idx this cycle.
- idx  out  N  binary index of the current highest-priority pending bit.
- last  out  1  idx is the final pending bit of the vector.
- busy  out  1  vector being serialized (state EMIT).

## Operation
- Two states: IDLE and EMIT. Register pend[2^N-1:0] holds the bits still to emit.
- IDLE behaviour:
  - in_ready=1, out_valid=0.
  - in_valid&&req!=0: pend<=req, go to EMIT.
  - in_valid&&req==0: vector accepted and dropped; stay IDLE.
- EMIT behaviour:
  - in_ready=0, out_valid=1.
  - idx = highest set index in pend.
  - last = (pend has exactly one bit set).
  - On out_ready: clear pend[idx]. If last, go to IDLE, else stay.
- out_valid/idx/last hold stable while out_valid&&!out_ready.
- flush (any state): pend<=0, state<=IDLE. It overrides a same-cycle out_ready or in_valid; the beat in that cycle counts as consumed by the sink, and the input is not accepted.
- busy = (state==EMIT).

## Timing
- Reset values (async assert): state=IDLE, pend=0, in_ready=1, out_valid=0, idx=0, last=0, busy=0.
- Reset deassertion takes effect on the next clk edge. Reset mid-EMIT abandons the vector with no further output.
- Latency: input handshake at cycle t gives out_valid=1 at t+1.
- Throughput: a vector with k set bits occupies k output beats. in_ready rises the cycle after the last beat, so the minimum period is k+1 cycles per vector.
- out_valid, busy and in_ready are decoded from registered state only. idx and last are combinational from pend only. There is no combinational path from any input to any output.
- out_valid never drops without a handshake, flush or reset.

## Configuration
- PRIO_ENC_LSB_FIRST_EN:
  - Undefined (default): priority is highest index first, matching the decoder (index 2^N-1 wins).
  - Defined: lowest index first. idx is the lowest set bit of pend, and last is unchanged in meaning.
- The interface is identical either way.

## Structure
- Shared package/header enc_dec_pkg:
  - State encoding localparams ST_IDLE=1'b0, ST_EMIT=1'b1.
  - Helper function for popcount==1.
- One sub-module, prio_find, parameter N:
  - Purely combinational; vec -> idx, any.
  - Direction selected by PRIO_ENC_LSB_FIRST_EN.
  - Instantiated once on pend.

## Test plan
All scenarios use N=2.
- Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, idx=0, last=0, busy=0. Assert rst_n low asynchronously mid-clock -> outputs clear before the next edge.
- Full vector, out_ready=1: req=4'b1011 -> idx 3,1,0 on consecutive cycles, last=1 only on idx 0. in_ready=1 the cycle after. With PRIO_ENC_LSB_FIRST_EN defined -> 0,1,3.
- Backpressure: req=4'b0110 with out_ready toggling 0,0,1,0,1 -> idx=2 held for 3 cycles then idx=1 (last=1) held until accepted. No beats lost or duplicated.
- Zero vector: in_valid with req=4'b0000 -> accepted, out_valid stays 0, in_ready stays 1.
- Flush mid-stream: req=4'b1111, flush asserted with out_ready on the second beat -> emitted beats are 3 then 2. Next cycle out_valid=0 and in_ready=1. A new req=4'b0001 gives idx=0, last=1.
- Reset mid-EMIT: req=4'b1100, rst_n pulsed low after the first beat -> out_valid=0 immediately and pend cleared. After release, the next vector is serialized correctly.

Source files
------------

// File: rtl/enc_dec_pkg.sv
// enc_dec_pkg -- definitions shared by the priority encoder/serializer and
// the one-hot decoder it feeds.
//   ST_IDLE / ST_EMIT : serializer state encoding (also wrapped as state_t)
//   single_bit()      : true when a vector has exactly one bit set
// Optional build macro: PRIO_ENC_LSB_FIRST_EN (used by prio_find).
package enc_dec_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_EMIT = ST_EMIT
  } state_t;

  // Vectors up to 64 bits (N <= 6); callers zero-extend their operand.
  // v & (v-1) strips the lowest set bit, so the result is zero only for
  // vectors with at most one bit set.
  function automatic logic single_bit(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find -- combinational priority search over a 2^N-bit vector.
//   vec  in  2^N  candidate bits
//   idx  out N    index of the winning set bit (0 when vec is empty)
//   any  out 1    vec has at least one bit set
// Optional build macro: PRIO_ENC_LSB_FIRST_EN
//   undefined : highest set index wins
//   defined   : lowest set index wins
module prio_find #(
  parameter int N = 2
) (
  input  logic [(1<<N)-1:0] vec,
  output logic [N-1:0]      idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // The scan runs toward the winning end so the last hit overwrites
    // earlier ones, giving the required priority without a break.
`ifdef PRIO_ENC_LSB_FIRST_EN
    for (int i = (1 << N) - 1; i >= 0; i--) begin
      if (vec[i]) idx = N'(i);
    end
`else
    for (int i = 0; i < (1 << N); i++) begin
      if (vec[i]) idx = N'(i);
    end
`endif
  end

endmodule

// File: rtl/prio_enc_serializer.sv
// prio_enc_serializer -- sequential 2^N-to-N priority encoder. Accepts a
// multi-hot request vector and emits the index of every set bit, one per
// output handshake, in priority order.
//   clk        in  1    rising-edge clock
//   rst_n      in  1    asynchronous active-low reset
//   in_valid   in  1    req valid
//   in_ready   out 1    ready for a new vector (IDLE)
//   req        in  2^N  multi-hot request vector
//   flush      in  1    synchronous abort of the pending vector
//   out_valid  out 1    idx/last valid (EMIT)
//   out_ready  in  1    sink accepts idx
//   idx        out N    current highest-priority pending index
//   last       out 1    idx is the final pending bit
//   busy       out 1    vector being serialized
// Optional build macro: PRIO_ENC_LSB_FIRST_EN (lowest index first).
module prio_enc_serializer
  import enc_dec_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [(1<<N)-1:0] req,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      idx,
  output logic              last,
  output logic              busy
);

  localparam int W = 1 << N;

  state_t         state_reg, state_next;
  logic [W-1:0]   pend_reg, pend_next;
  logic [W-1:0]   clr_mask;
  logic           any;

  prio_find #(.N(N)) u_find (
    .vec (pend_reg),
    .idx (idx),
    .any (any)
  );

  // Handshake flags come from the state register only; idx/last only from
  // pend, so no input reaches an output combinationally.
  assign last      = single_bit(64'(pend_reg));
  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_EMIT);
  assign busy      = (state_reg == S_EMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pend_next       = pend_reg;
    clr_mask        = '0;
    clr_mask[idx]   = 1'b1;
    if (flush) begin
      // Abort wins over both handshakes in the same cycle.
      state_next = S_IDLE;
      pend_next  = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // An all-zero vector is accepted and simply dropped.
          if (in_valid && (req != '0)) begin
            pend_next  = req;
            state_next = S_EMIT;
          end
        end
        S_EMIT: begin
          if (!any) begin
            // Unreachable in normal operation; recover rather than stall.
            state_next = S_IDLE;
          end else if (out_ready) begin
            pend_next = pend_reg & ~clr_mask;
            if (last) state_next = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
          pend_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_enc_serializer.sv
module tb_prio_enc_serializer;

  localparam int N = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] req;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] idx;
  logic       last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;

  prio_enc_serializer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .last      (last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference ordering of the beats a vector must produce.
  task automatic push_vec(input logic [3:0] r);
    int remaining;
    remaining = $countones(r);
`ifdef PRIO_ENC_LSB_FIRST_EN
    for (int i = 0; i < 4; i++) begin
`else
    for (int i = 3; i >= 0; i--) begin
`endif
      if (r[i]) begin
        remaining--;
        sb.push_back('{i, (remaining == 0) ? 1 : 0});
      end
    end
  endtask

  // Drives one vector; returns at posedge+1 after acceptance.
  task automatic send(input logic [3:0] r);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_timeout", int'(in_ready), 1);
    in_valid = 1'b1;
    req      = r;
    push_vec(r);
    $display("send req=%b", r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    req      = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", int'(out_valid), 0);
  endtask

  // Scoreboard: every consumed beat (handshake or flush) pops one entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && (out_ready || flush)) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        $display("beat idx=%0d last=%0d flush=%0d", idx, last, flush);
        chk("beat_idx", int'(idx), mon_e.idx);
        chk("beat_last", int'(last), mon_e.last);
      end
      if (flush) sb.delete();
    end
  end

`ifdef PRIO_ENC_LSB_FIRST_EN
  localparam int BP_FIRST = 1;
  localparam int BP_SECOND = 2;
`else
  localparam int BP_FIRST = 2;
  localparam int BP_SECOND = 1;
`endif

  initial begin
    logic [4:0] bp_ready;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    req       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;

    // Reset held with random inputs.
    for (int c = 0; c < 4; c++) begin
      in_valid  = 1'($urandom);
      req       = 4'($urandom);
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_idx", int'(idx), 0);
      chk("rst_last", int'(last), 0);
      chk("rst_busy", int'(busy), 0);
    end
    in_valid = 1'b0; req = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full vector with free-running sink.
    out_ready = 1'b1;
    send(4'b1011);
    chk("lat_out_valid", int'(out_valid), 1);
    chk("lat_busy", int'(busy), 1);
    chk("lat_in_ready", int'(in_ready), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("full_in_ready_after", int'(in_ready), 1);
    chk("full_out_valid_after", int'(out_valid), 0);
    chk("full_sb_empty", sb.size(), 0);

    // Backpressure: held values while the sink stalls.
    out_ready = 1'b0;
    send(4'b0110);
    bp_ready = 5'b10100;  // bit k = out_ready in cycle k: 0,0,1,0,1
    for (int k = 0; k < 5; k++) begin
      out_ready = bp_ready[k];
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_idx", int'(idx), (k < 3) ? BP_FIRST : BP_SECOND);
      chk("bp_last", int'(last), (k < 3) ? 0 : 1);
      @(posedge clk); #1;
    end
    chk("bp_done_valid", int'(out_valid), 0);
    chk("bp_sb_empty", sb.size(), 0);
    out_ready = 1'b1;

    // Zero vector is swallowed.
    send(4'b0000);
    chk("zero_out_valid", int'(out_valid), 0);
    chk("zero_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("zero_out_valid2", int'(out_valid), 0);

    // Flush on the second beat.
    send(4'b1111);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    chk("flush_sb_empty", sb.size(), 0);
    send(4'b0001);
    chk("post_flush_idx", int'(idx), 0);
    chk("post_flush_last", int'(last), 1);
    drain();

    // Asynchronous reset in the middle of a vector.
    send(4'b1100);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(idx), 0);
    chk("mid_rst_last", int'(last), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", int'(out_valid), 0);
    send(4'b1010);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
